booth4_divider: RTL

- Sequential integer divider; the inverse-operation sibling of booth4_multiplier in the same arithmetic unit.
- Accepts dividend/divisor with per-operand signedness flags over a valid/ready handshake.
- Iterates one restoring-division step per cycle and returns quotient and remainder on a second valid/ready handshake.
- Feeds the same result-writeback path as the multiplier.

---
 rtl/booth4_divider.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/booth4_divider.sv
// Sequential restoring divider: one quotient bit per cycle, signed/unsigned operands.
// Optional build macro DIV_FAST_SPECIAL_EN short-cuts divide-by-zero and signed overflow.
module booth4_divider #(
    parameter int DIV_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DIV_SIZE-1:0] in_op1,
    input  logic [DIV_SIZE-1:0] in_op2,
    input  logic                in_op1_signed,
    input  logic                in_op2_signed,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DIV_SIZE-1:0] out_quo,
    output logic [DIV_SIZE-1:0] out_rem,
    output logic                out_valid,
    input  logic                out_ready
);
    localparam int CNT_W = $clog2(DIV_SIZE) + 1;
    localparam logic [DIV_SIZE-1:0] ONES    = '1;
    localparam logic [DIV_SIZE-1:0] MOST_NEG = {1'b1, {(DIV_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_SIZE-1:0] rem_q, rem_d;
    logic [DIV_SIZE-1:0] quo_q, quo_d;
    logic [DIV_SIZE-1:0] dvs_q, dvs_d;
    logic                quo_neg_q, quo_neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;
    logic [DIV_SIZE-1:0] out_quo_q, out_quo_d;
    logic [DIV_SIZE-1:0] out_rem_q, out_rem_d;

    logic                sign1, sign2, dz_in, ovf_in;
    logic [DIV_SIZE-1:0] mag1, mag2;
    logic [DIV_SIZE:0]   sh_rem, trial;
    logic [DIV_SIZE-1:0] fix_quo, fix_rem;

    always_comb begin
        sign1  = in_op1[DIV_SIZE-1] & in_op1_signed;
        sign2  = in_op2[DIV_SIZE-1] & in_op2_signed;
        mag1   = sign1 ? -in_op1 : in_op1;
        mag2   = sign2 ? -in_op2 : in_op2;
        dz_in  = (in_op2 == '0);
        ovf_in = sign1 & sign2 & (in_op1 == MOST_NEG) & (in_op2 == ONES);

        // Remainder is always below the divisor, so DIV_SIZE+1 bits hold the shifted value.
        sh_rem = {rem_q, quo_q[DIV_SIZE-1]};
        trial  = sh_rem - {1'b0, dvs_q};

        // With a zero divisor the magnitude path leaves |op1| in rem, and the
        // sign restore below turns that back into the raw dividend.
        fix_quo = quo_neg_q ? -quo_q : quo_q;
        fix_rem = rem_neg_q ? -rem_q : rem_q;
        if (dz_q) begin
            fix_quo = ONES;
        end
        if (ovf_q) begin
            fix_quo = MOST_NEG;
            fix_rem = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        out_quo_d = out_quo_q;
        out_rem_d = out_rem_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_d     = '0;
                    quo_d     = mag1;
                    dvs_d     = mag2;
                    quo_neg_d = sign1 ^ sign2;
                    rem_neg_d = sign1;
                    dz_d      = dz_in;
                    ovf_d     = ovf_in;
                    cnt_d     = CNT_W'(DIV_SIZE - 1);
                    state_d   = CALC;
`ifdef DIV_FAST_SPECIAL_EN
                    if (dz_in) begin
                        out_quo_d = ONES;
                        out_rem_d = in_op1;
                        state_d   = DONE;
                    end else if (ovf_in) begin
                        out_quo_d = MOST_NEG;
                        out_rem_d = '0;
                        state_d   = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (!trial[DIV_SIZE]) begin
                    rem_d = trial[DIV_SIZE-1:0];
                    quo_d = {quo_q[DIV_SIZE-2:0], 1'b1};
                end else begin
                    rem_d = sh_rem[DIV_SIZE-1:0];
                    quo_d = {quo_q[DIV_SIZE-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                out_quo_d = fix_quo;
                out_rem_d = fix_rem;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            out_quo_q <= '0;
            out_rem_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            out_quo_q <= out_quo_d;
            out_rem_q <= out_rem_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_quo   = out_quo_q;
    assign out_rem   = out_rem_q;

endmodule
